// File: rtl/fsm_pulse_stretch.sv
// fsm_pulse_stretch: multi-channel Moore pulse stretcher with a forced-low hold-off.
// Each channel runs its own IDLE/ACTIVE/STRETCH/HOLDOFF FSM with a private counter.
// Build macro FSM_PULSE_STRETCH_RETRIGGER_EN: a high input seen in STRETCH sends the
// channel back to ACTIVE so y stays high; without it the input is ignored in STRETCH.
module fsm_pulse_stretch #(
   parameter int unsigned CHANNELS       = 1,
   parameter int unsigned STRETCH_CYCLES = 1,
   parameter int unsigned HOLDOFF_CYCLES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [CHANNELS-1:0] in_sig,
   output logic [CHANNELS-1:0] y,
   output logic [CHANNELS-1:0] done,
   output logic                busy
);

   localparam int unsigned CntMax =
      (STRETCH_CYCLES > HOLDOFF_CYCLES) ? STRETCH_CYCLES : HOLDOFF_CYCLES;
   localparam int unsigned CNT_W  = $clog2(CntMax + 1);

   // Reload values are "cycles - 1" because the zero count is itself a cycle in the state.
   localparam logic [CNT_W-1:0] StretchLoad = CNT_W'(STRETCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] HoldoffLoad =
      CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StActive  = 2'd1,
      StStretch = 2'd2,
      StHoldoff = 2'd3
   } state_e;

   state_e             state_q [CHANNELS];
   state_e             state_d [CHANNELS];
   logic [CNT_W-1:0]   cnt_q   [CHANNELS];
   logic [CNT_W-1:0]   cnt_d   [CHANNELS];
   logic [CHANNELS-1:0] done_q;
   logic [CHANNELS-1:0] done_d;

   // Per-channel next-state, counter and done-pulse logic.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         done_d[i]  = 1'b0;
         if (!en) begin
            // Global disable wins over everything and never produces a done pulse.
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               StIdle: begin
                  if (in_sig[i]) begin
                     state_d[i] = StActive;
                  end
               end
               StActive: begin
                  if (!in_sig[i]) begin
                     state_d[i] = StStretch;
                     cnt_d[i]   = StretchLoad;
                  end
               end
               StStretch: begin
`ifdef FSM_PULSE_STRETCH_RETRIGGER_EN
                  if (in_sig[i]) begin
                     state_d[i] = StActive;
                     cnt_d[i]   = '0;
                  end else
`endif
                  if (cnt_q[i] == '0) begin
                     if (HOLDOFF_CYCLES > 0) begin
                        state_d[i] = StHoldoff;
                        cnt_d[i]   = HoldoffLoad;
                     end else begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = '0;
                        done_d[i]  = 1'b1;
                     end
                  end else begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                  end
               end
               StHoldoff: begin
                  // Input deliberately ignored: an edge during hold-off is dropped.
                  if (cnt_q[i] == '0) begin
                     state_d[i] = StIdle;
                     done_d[i]  = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                  end
               end
               default: begin
                  state_d[i] = StIdle;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // State, counter and done registers; reset is asynchronous and pulses nothing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end
         done_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         done_q <= done_d;
      end
   end

   // Moore outputs decoded from the registered state.
   always_comb begin
      y    = '0;
      busy = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         y[i] = (state_q[i] == StActive) || (state_q[i] == StStretch);
         busy = busy | (state_q[i] != StIdle);
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_fsm_pulse_stretch.sv
// Scoreboard bench for fsm_pulse_stretch: a driver applies directed vectors and queues
// the hand-computed response; a negedge monitor pops and compares.
module tb_fsm_pulse_stretch;

   typedef struct {
      bit         sel_b;
      logic [1:0] y;
      logic [1:0] done;
      logic       busy;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       en;
   logic [0:0] in_a;
   logic [0:0] y_a;
   logic [0:0] done_a;
   logic       busy_a;
   logic [1:0] in_b;
   logic [1:0] y_b;
   logic [1:0] done_b;
   logic       busy_b;

   exp_t  exp_q  [$];
   string name_q [$];
   int    checks;
   int    failures;

   fsm_pulse_stretch dut_a (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .in_sig (in_a),
      .y      (y_a),
      .done   (done_a),
      .busy   (busy_a)
   );

   fsm_pulse_stretch #(
      .CHANNELS       (2),
      .STRETCH_CYCLES (3),
      .HOLDOFF_CYCLES (2)
   ) dut_b (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .in_sig (in_b),
      .y      (y_b),
      .done   (done_b),
      .busy   (busy_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply one vector just after a falling edge and queue the response expected
   // after the following rising edge.
   task automatic step(input bit sel_b, input logic en_v, input logic [1:0] in_v,
                       input logic [1:0] ey, input logic [1:0] ed, input logic eb,
                       input string nm);
      exp_t e;
      @(negedge clk);
      #1;
      en = en_v;
      if (sel_b) begin
         in_b = in_v;
         in_a = 1'b0;
      end else begin
         in_a = in_v[0];
         in_b = 2'b00;
      end
      e.sel_b = sel_b;
      e.y     = ey;
      e.done  = ed;
      e.busy  = eb;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Immediate comparison, used where the response is not tied to a clock edge.
   task automatic check_now(input string nm, input logic [1:0] ay, input logic [1:0] ad,
                            input logic ab, input logic [1:0] ey, input logic [1:0] ed,
                            input logic eb);
      checks++;
      if (ay !== ey || ad !== ed || ab !== eb) begin
         failures++;
         $display("FAIL %s: got y=%b done=%b busy=%b, want y=%b done=%b busy=%b",
                  nm, ay, ad, ab, ey, ed, eb);
      end
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s: %0d responses still pending, want 0", nm, exp_q.size());
      end
   endtask

   // Monitor: one queued response per falling edge, well away from the active edge.
   initial begin : monitor
      exp_t       e;
      string      nm;
      logic [1:0] ay;
      logic [1:0] ad;
      logic       ab;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.sel_b) begin
               ay = y_b;
               ad = done_b;
               ab = busy_b;
            end else begin
               ay = {1'b0, y_a};
               ad = {1'b0, done_a};
               ab = busy_a;
            end
            checks++;
            if (ay !== e.y || ad !== e.done || ab !== e.busy) begin
               failures++;
               $display("FAIL %s: got y=%b done=%b busy=%b, want y=%b done=%b busy=%b",
                        nm, ay, ad, ab, e.y, e.done, e.busy);
            end
         end
      end
   end

   initial begin : driver
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      en       = 1'b0;
      in_a     = 1'b0;
      in_b     = 2'b00;
      #3;
      check_now("reset_a", {1'b0, y_a}, {1'b0, done_a}, busy_a, 2'b00, 2'b00, 1'b0);
      check_now("reset_b", y_b, done_b, busy_b, 2'b00, 2'b00, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b0;

      // Default single channel: basic pattern, then hold-off boundaries.
      step(0, 1, 2'b00, 2'b00, 2'b00, 0, "a_idle");
      step(0, 1, 2'b01, 2'b01, 2'b00, 1, "a_active1");
      step(0, 1, 2'b01, 2'b01, 2'b00, 1, "a_active2");
      step(0, 1, 2'b00, 2'b01, 2'b00, 1, "a_stretch");
      step(0, 1, 2'b00, 2'b00, 2'b00, 1, "a_holdoff");
      step(0, 1, 2'b00, 2'b00, 2'b01, 0, "a_done");
      step(0, 1, 2'b00, 2'b00, 2'b00, 0, "a_done_clear");
      step(0, 1, 2'b01, 2'b01, 2'b00, 1, "a2_active");
      step(0, 1, 2'b00, 2'b01, 2'b00, 1, "a2_stretch");
      step(0, 1, 2'b00, 2'b00, 2'b00, 1, "a2_holdoff");
      step(0, 1, 2'b01, 2'b00, 2'b01, 0, "a2_holdoff_in_ignored");
      step(0, 1, 2'b01, 2'b01, 2'b00, 1, "a2_rearm_from_idle");
      step(0, 1, 2'b00, 2'b01, 2'b00, 1, "a3_stretch");
      step(0, 1, 2'b00, 2'b00, 2'b00, 1, "a3_holdoff");
      step(0, 1, 2'b00, 2'b00, 2'b01, 0, "a3_done");
      step(0, 1, 2'b00, 2'b00, 2'b00, 0, "a3_idle");

      // Two channels, stretch 3, hold-off 2: one-cycle pulse on ch0.
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "b_idle");
      step(1, 1, 2'b01, 2'b01, 2'b00, 1, "b_pulse_active");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "b_stretch2");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "b_stretch1");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "b_stretch0");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "b_holdoff1");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "b_holdoff0");
      step(1, 1, 2'b00, 2'b00, 2'b01, 0, "b_done");
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "b_done_clear");

      // Re-pulse during hold-off is lost; pulse in the following IDLE re-arms.
      step(1, 1, 2'b01, 2'b01, 2'b00, 1, "h_active");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "h_stretch2");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "h_stretch1");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "h_stretch0");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "h_holdoff1");
      step(1, 1, 2'b01, 2'b00, 2'b00, 1, "h_pulse_ignored");
      step(1, 1, 2'b00, 2'b00, 2'b01, 0, "h_done");
      step(1, 1, 2'b01, 2'b01, 2'b00, 1, "h_rearm");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "h2_stretch2");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "h2_stretch1");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "h2_stretch0");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "h2_holdoff1");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "h2_holdoff0");
      step(1, 1, 2'b00, 2'b00, 2'b01, 0, "h2_done");

      // Second pulse arriving while in STRETCH.
      step(1, 1, 2'b01, 2'b01, 2'b00, 1, "r_active");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "r_stretch2");
      step(1, 1, 2'b01, 2'b01, 2'b00, 1, "r_second_pulse");
`ifdef FSM_PULSE_STRETCH_RETRIGGER_EN
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "r_restretch2");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "r_restretch1");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "r_restretch0");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "r_holdoff1");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "r_holdoff0");
      step(1, 1, 2'b00, 2'b00, 2'b01, 0, "r_done");
`else
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "r_stretch0");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "r_holdoff1");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "r_holdoff0");
      step(1, 1, 2'b00, 2'b00, 2'b01, 0, "r_done");
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "r_idle1");
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "r_idle2");
`endif
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "r_final_idle");

      // Asynchronous reset between clock edges while ch0 is stretching.
      step(1, 1, 2'b01, 2'b01, 2'b00, 1, "x_active");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "x_stretch");
      drain("x_drain");
      check_now("x_pre_rst", y_b, done_b, busy_b, 2'b01, 2'b00, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check_now("x_async_rst_b", y_b, done_b, busy_b, 2'b00, 2'b00, 1'b0);
      check_now("x_async_rst_a", {1'b0, y_a}, {1'b0, done_a}, busy_a, 2'b00, 2'b00, 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "x_post_rst1");
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "x_post_rst2");

      // Global enable: abort ACTIVE and STRETCH on both channels, no done pulse.
      step(1, 1, 2'b11, 2'b11, 2'b00, 1, "e_both_active");
      step(1, 1, 2'b11, 2'b11, 2'b00, 1, "e_both_hold");
      step(1, 0, 2'b11, 2'b00, 2'b00, 0, "e_en_low_active");
      step(1, 1, 2'b11, 2'b11, 2'b00, 1, "e_en_restored");
      step(1, 1, 2'b00, 2'b11, 2'b00, 1, "e_both_stretch");
      step(1, 0, 2'b00, 2'b00, 2'b00, 0, "e_en_low_stretch");
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "e_no_done");

      // Staggered channels run independently.
      step(1, 1, 2'b10, 2'b10, 2'b00, 1, "i_ch1_active");
      step(1, 1, 2'b01, 2'b11, 2'b00, 1, "i_ch0_active");
      step(1, 1, 2'b00, 2'b11, 2'b00, 1, "i_both_stretch");
      step(1, 1, 2'b00, 2'b11, 2'b00, 1, "i_both_stretch_b");
      step(1, 1, 2'b00, 2'b01, 2'b00, 1, "i_ch1_holdoff");
      step(1, 1, 2'b00, 2'b00, 2'b00, 1, "i_both_holdoff");
      step(1, 1, 2'b00, 2'b00, 2'b10, 1, "i_ch1_done");
      step(1, 1, 2'b00, 2'b00, 2'b01, 0, "i_ch0_done");
      step(1, 1, 2'b00, 2'b00, 2'b00, 0, "i_idle");

      drain("final_drain");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
